ysyx_22050243_pipe_ctrl: RTL
============================

Name: ysyx_22050243_pipe_ctrl

Overview:
Central stall/flush scheduler for the 5-stage ysyx_22050243 pipeline (IF/ID/EX/MEM/WB).
- Arbitrates hazard sources: jalr/load-use stall, fetch wait, data-memory wait, EX redirect, WB trap, FENCE.I.
- Produces per-stage pipeline-register enables and flushes, plus the PC redirect.
- Owns the sequential cases: a redirect deferred behind an in-flight fetch, and the FENCE.I drain / I-cache flush / refetch sequence.

Parameters:
PC_WIDTH, 32, width of PC and redirect targets
DRAIN_CYCLES, 3, cycles to retire EX/MEM/WB before I-cache flush

Ports:
clk  in  1  pipeline clock
rst_n  in  1  reset, asynchronous, active-low
stall_jalr  in  1  jalr operand hazard in ID
stall_load_use  in  1  load-use hazard in ID
imem_wait  in  1  fetch in flight, IF data not ready
dmem_wait  in  1  MEM-stage access not complete
redirect_valid  in  1  taken branch/jump resolved in EX
redirect_pc  in  PC_WIDTH  redirect target
trap_valid  in  1  exception/mret committing in WB
trap_pc  in  PC_WIDTH  trap target
fence_i_id  in  1  FENCE.I decoded in ID
pc_id  in  PC_WIDTH  PC of ID instruction
icache_flush_done  in  1  I-cache invalidate complete
pc_en  out  1  PC register update enable
if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage-register enables
if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  load bubble into stage register
pc_redirect  out  1  PC loads pc_target this cycle
pc_target  out  PC_WIDTH  redirect address
icache_flush  out  1  I-cache invalidate request (level)
busy  out  1  state != RUN

Behaviour:
- States: RUN, REDIR_WAIT, DRAIN, ICFLUSH, REFETCH.
- Registered: state, redir_pc_q, fence_pc_q, drain_cnt (clog2(DRAIN_CYCLES+1) bits).
- Reset: state=RUN, all registers 0.
- Outputs are combinational from state and inputs. In RUN with all inputs low: every enable=1, every flush=0, pc_redirect=0, icache_flush=0, busy=0.
- A flush overrides its enable: the bubble is written regardless of the enable.
- RUN priority, highest first:
  1. trap_valid: flush all four stage registers; pc_redirect=1; pc_target=trap_pc. Wins over dmem_wait.
  2. dmem_wait: all enables=0, no flushes, full freeze.
  3. redirect_valid:
     - imem_wait=0: if_id_flush=1, id_ex_flush=1, pc_redirect=1, pc_target=redirect_pc.
     - imem_wait=1: same flushes, pc_en=0, capture redirect_pc into redir_pc_q, go to REDIR_WAIT.
  4. fence_i_id: pc_en=0, if_id_en=0, id_ex_flush=1; fence_pc_q<=pc_id; drain_cnt<=DRAIN_CYCLES; go to DRAIN.
  5. stall_jalr | stall_load_use: pc_en=0, if_id_en=0, id_ex_flush=1; EX/MEM/WB advance.
  6. imem_wait: pc_en=0, if_id_flush=1; downstream advances.
- REDIR_WAIT:
  - pc_en=0, if_id_flush=1.
  - When imem_wait=0: pc_redirect=1, pc_target=redir_pc_q, go to RUN. The stale fetch is discarded.
- DRAIN:
  - pc_en=0, if_id_en=0, id_ex_flush=1.
  - drain_cnt decrements only when dmem_wait=0. dmem_wait freezes EX/MEM/WB as in RUN.
  - drain_cnt==1 and dmem_wait=0: go to ICFLUSH.
- ICFLUSH:
  - icache_flush=1, pc_en=0, if_id_en=0, id_ex_flush=1.
  - On icache_flush_done: go to REFETCH. Done arriving in the first ICFLUSH cycle is accepted.
- REFETCH:
  - pc_redirect=1, pc_target=fence_pc_q+4 (mod 2^PC_WIDTH), if_id_flush=1.
  - If imem_wait=1: stay in REFETCH, holding redirect and pc_target, until it clears. Then go to RUN.
- trap_valid in any non-RUN state: RUN trap response, state<=RUN. Pending redirect, drain or flush is abandoned, and icache_flush drops the same cycle.
- redirect_valid and fence_i_id are ignored outside RUN. They cannot legally occur there because ID/EX hold bubbles.
- Asynchronous reset mid-sequence returns to RUN immediately; icache_flush deasserts asynchronously.

Optional Feature:
Macro: YSYX_22050243_PIPE_PERF_EN.
- Defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0], both reset to 0, wrapping at 2^32.
  - perf_stall_cnt: +1 per cycle with pc_en=0 and no redirect.
  - perf_flush_cnt: +1 per cycle with if_id_flush=1.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, idle inputs -> all enables=1, flushes=0, busy=0; pulse rst_n low mid-DRAIN -> state RUN, icache_flush=0 at once.
- stall_load_use=1 for 2 cycles -> pc_en=0, if_id_en=0, id_ex_flush=1 both cycles; ex_mem_en=1.
- redirect_valid=1, redirect_pc=0x8000_0040, imem_wait=1 for 3 cycles -> REDIR_WAIT, pc_en=0; cycle imem_wait falls -> pc_redirect=1, pc_target=0x8000_0040, then RUN.
- fence_i_id=1, pc_id=0x8000_0100, dmem_wait=1 in 2nd DRAIN cycle -> icache_flush rises after 4 cycles; done 2 cycles later -> pc_target=0x8000_0104, pc_redirect=1.
- trap_valid=1, trap_pc=0x8000_0004 together with dmem_wait=1 and redirect_valid=1 -> all four flushes=1, pc_target=0x8000_0004.
- trap_valid during ICFLUSH -> icache_flush=0 same cycle, trap redirect, busy=0 next cycle.

Source files
------------

// File: rtl/ysyx_22050243_pipe_ctrl_if.sv
// ysyx_22050243_pipe_ctrl_if
//   Bundles every hazard input and every stall/flush/redirect output of the
//   pipeline scheduler. clk and rst_n stay as plain ports on the controller.
//
//   master : pipeline side (drives hazards, consumes enables/flushes/redirect)
//   slave  : scheduler side (ysyx_22050243_pipe_ctrl)
//
//   Hazards  : stall_jalr, stall_load_use, imem_wait, dmem_wait,
//              redirect_valid/redirect_pc, trap_valid/trap_pc,
//              fence_i_id/pc_id, icache_flush_done
//   Controls : pc_en, *_en, *_flush, pc_redirect/pc_target, icache_flush, busy
interface ysyx_22050243_pipe_ctrl_if #(
  parameter int PC_WIDTH = 32
);
  logic                stall_jalr;
  logic                stall_load_use;
  logic                imem_wait;
  logic                dmem_wait;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                trap_valid;
  logic [PC_WIDTH-1:0] trap_pc;
  logic                fence_i_id;
  logic [PC_WIDTH-1:0] pc_id;
  logic                icache_flush_done;

  logic                pc_en;
  logic                if_id_en;
  logic                id_ex_en;
  logic                ex_mem_en;
  logic                mem_wb_en;
  logic                if_id_flush;
  logic                id_ex_flush;
  logic                ex_mem_flush;
  logic                mem_wb_flush;
  logic                pc_redirect;
  logic [PC_WIDTH-1:0] pc_target;
  logic                icache_flush;
  logic                busy;

  modport master (
    output stall_jalr, stall_load_use, imem_wait, dmem_wait,
           redirect_valid, redirect_pc, trap_valid, trap_pc,
           fence_i_id, pc_id, icache_flush_done,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
           pc_redirect, pc_target, icache_flush, busy
  );

  modport slave (
    input  stall_jalr, stall_load_use, imem_wait, dmem_wait,
           redirect_valid, redirect_pc, trap_valid, trap_pc,
           fence_i_id, pc_id, icache_flush_done,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
           pc_redirect, pc_target, icache_flush, busy
  );
endinterface

// File: rtl/ysyx_22050243_pipe_ctrl.sv
// ysyx_22050243_pipe_ctrl
//   Central stall/flush scheduler for the 5-stage IF/ID/EX/MEM/WB pipeline.
//   Arbitrates trap, data-memory wait, EX redirect, FENCE.I, jalr/load-use
//   stalls and fetch wait; sequences deferred redirects and the FENCE.I
//   drain / I-cache invalidate / refetch.
//
//   Ports:
//     clk, rst_n  pipeline clock, asynchronous active-low reset
//     ctl         ysyx_22050243_pipe_ctrl_if.slave (hazards in, controls out)
//     perf_stall_cnt, perf_flush_cnt (32b) only when
//                 YSYX_22050243_PIPE_PERF_EN is defined
//
//   Parameters: PC_WIDTH (must match the interface), DRAIN_CYCLES.
//
//   state        | meaning
//   -------------+------------------------------------------------------
//   S_RUN        | normal issue, single-cycle hazard arbitration
//   S_REDIR_WAIT | redirect captured, waiting for in-flight fetch to land
//   S_DRAIN      | FENCE.I held in ID, retiring EX/MEM/WB
//   S_ICFLUSH    | I-cache invalidate requested, waiting for done
//   S_REFETCH    | redirect to FENCE.I pc+4, held while a fetch is pending
//
//   Outputs are combinational from state and inputs; a flush takes
//   precedence over the corresponding enable inside the stage register.
module ysyx_22050243_pipe_ctrl #(
  parameter int PC_WIDTH     = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  ysyx_22050243_pipe_ctrl_if.slave ctl
`ifdef YSYX_22050243_PIPE_PERF_EN
  ,
  output logic [31:0]              perf_stall_cnt,
  output logic [31:0]              perf_flush_cnt
`endif
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_RUN        = 3'd0,
    S_REDIR_WAIT = 3'd1,
    S_DRAIN      = 3'd2,
    S_ICFLUSH    = 3'd3,
    S_REFETCH    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] redir_pc_q, redir_pc_d;
  logic [PC_WIDTH-1:0] fence_pc_q, fence_pc_d;
  logic [CNT_W-1:0]    drain_cnt_q, drain_cnt_d;

  logic                pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic                pc_redirect, icache_flush;
  logic [PC_WIDTH-1:0] pc_target;

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    pc_redirect  = 1'b0;
    pc_target    = '0;
    icache_flush = 1'b0;
    state_d      = state_q;
    redir_pc_d   = redir_pc_q;
    fence_pc_d   = fence_pc_q;
    drain_cnt_d  = drain_cnt_q;

    // A committing trap overrides everything, in every state, and abandons
    // any sequence in progress.
    if (ctl.trap_valid) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
      pc_redirect  = 1'b1;
      pc_target    = ctl.trap_pc;
      state_d      = S_RUN;
    end else begin
      case (state_q)
        S_RUN: begin
          if (ctl.dmem_wait) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
          end else if (ctl.redirect_valid) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (ctl.imem_wait) begin
              // Fetch bus busy: the PC can't move yet, so park the target.
              pc_en      = 1'b0;
              redir_pc_d = ctl.redirect_pc;
              state_d    = S_REDIR_WAIT;
            end else begin
              pc_redirect = 1'b1;
              pc_target   = ctl.redirect_pc;
            end
          end else if (ctl.fence_i_id) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            fence_pc_d  = ctl.pc_id;
            drain_cnt_d = CNT_W'(DRAIN_CYCLES);
            state_d     = S_DRAIN;
          end else if (ctl.stall_jalr || ctl.stall_load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end else if (ctl.imem_wait) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
          end
        end

        S_REDIR_WAIT: begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
          // The fetch that lands now is on the wrong path; the bubble above
          // discards it while the PC takes the parked target.
          if (!ctl.imem_wait) begin
            pc_redirect = 1'b1;
            pc_target   = redir_pc_q;
            state_d     = S_RUN;
          end
        end

        S_DRAIN: begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          if (ctl.dmem_wait) begin
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
          end else begin
            drain_cnt_d = drain_cnt_q - CNT_W'(1);
            if (drain_cnt_q == CNT_W'(1)) begin
              state_d = S_ICFLUSH;
            end
          end
        end

        S_ICFLUSH: begin
          icache_flush = 1'b1;
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_flush  = 1'b1;
          if (ctl.icache_flush_done) begin
            state_d = S_REFETCH;
          end
        end

        S_REFETCH: begin
          pc_redirect = 1'b1;
          pc_target   = fence_pc_q + PC_WIDTH'(4);
          if_id_flush = 1'b1;
          if (!ctl.imem_wait) begin
            state_d = S_RUN;
          end
        end

        default: begin
          state_d = S_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      redir_pc_q  <= '0;
      fence_pc_q  <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      redir_pc_q  <= redir_pc_d;
      fence_pc_q  <= fence_pc_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign ctl.pc_en        = pc_en;
  assign ctl.if_id_en     = if_id_en;
  assign ctl.id_ex_en     = id_ex_en;
  assign ctl.ex_mem_en    = ex_mem_en;
  assign ctl.mem_wb_en    = mem_wb_en;
  assign ctl.if_id_flush  = if_id_flush;
  assign ctl.id_ex_flush  = id_ex_flush;
  assign ctl.ex_mem_flush = ex_mem_flush;
  assign ctl.mem_wb_flush = mem_wb_flush;
  assign ctl.pc_redirect  = pc_redirect;
  assign ctl.pc_target    = pc_target;
  assign ctl.icache_flush = icache_flush;
  assign ctl.busy         = (state_q != S_RUN);

`ifdef YSYX_22050243_PIPE_PERF_EN
  // Stall cycles exclude redirect cycles, where the PC does move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (!pc_en && !pc_redirect) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (if_id_flush) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
